// File: rtl/aes128_cbc_chain_ctrl_if.sv
// aes128_cbc_chain_ctrl_if: host-side block streams of the CBC chaining controller
//   in_valid/in_ready/in_data/in_last     : input block stream (host -> controller)
//   out_valid/out_ready/out_data/out_last : output block stream (controller -> host)
//   master = host side, slave = controller side
interface aes128_cbc_chain_ctrl_if #(parameter int BLK_W = 128);
    logic             in_valid, in_ready, in_last;
    logic [BLK_W-1:0] in_data;
    logic             out_valid, out_ready, out_last;
    logic [BLK_W-1:0] out_data;
    modport master (output in_valid, in_data, in_last, out_ready,
                    input  in_ready, out_valid, out_data, out_last);
    modport slave  (input  in_valid, in_data, in_last, out_ready,
                    output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/aes128_cbc_chain_ctrl.sv
// aes128_cbc_chain_ctrl: multi-block AES-128 CBC chaining controller (enc/dec) around an iterative core
//   clk, reset           : clock, asynchronous active-high reset
//   iv_load, iv          : IV load pulse and value (IDLE only)
//   mode                 : 0 = encrypt, 1 = decrypt, sampled on the first block of a message
//   host                 : input/output block streams (slave side)
//   core_start/core_decrypt/core_din/core_done/core_dout : AES core start/done handshake
//   busy, blk_cnt        : FSM not idle, blocks completed in the current message
module aes128_cbc_chain_ctrl #(
    parameter int BLK_W = 128,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   iv_load,
    input  logic [BLK_W-1:0]       iv,
    input  logic                   mode,
    aes128_cbc_chain_ctrl_if.slave host,
    output logic                   core_start,
    output logic                   core_decrypt,
    output logic [BLK_W-1:0]       core_din,
    input  logic                   core_done,
    input  logic [BLK_W-1:0]       core_dout,
    output logic                   busy,
    output logic [CNT_W-1:0]       blk_cnt
);
    typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;
    state_t           state;
    logic [BLK_W-1:0] iv_q, chain, in_q;
    logic             last_q, mode_n;
    // an IV load in the same cycle takes priority over accepting a block
    assign host.in_ready = (state == IDLE) && !iv_load;
    // core_decrypt doubles as the per-message mode register
    assign mode_n = (blk_cnt == '0) ? mode : core_decrypt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            iv_q          <= '0;
            chain         <= '0;
            in_q          <= '0;
            last_q        <= 1'b0;
            core_start    <= 1'b0;
            core_decrypt  <= 1'b0;
            core_din      <= '0;
            busy          <= 1'b0;
            blk_cnt       <= '0;
            host.out_valid <= 1'b0;
            host.out_data  <= '0;
            host.out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iv_load) begin
                        iv_q  <= iv;
                        chain <= iv;
                    end else if (host.in_valid) begin
                        in_q         <= host.in_data;
                        last_q       <= host.in_last;
                        core_decrypt <= mode_n;
                        core_din     <= mode_n ? host.in_data : host.in_data ^ chain;
                        core_start   <= 1'b1;
                        busy         <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    core_start <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        host.out_data  <= core_decrypt ? core_dout ^ chain : core_dout;
                        chain          <= core_decrypt ? in_q : core_dout;
                        host.out_last  <= last_q;
                        host.out_valid <= 1'b1;
                        state          <= OUT;
                    end
                end
                OUT: begin
                    if (host.out_ready) begin
                        host.out_valid <= 1'b0;
                        busy           <= 1'b0;
                        blk_cnt        <= host.out_last ? '0 : blk_cnt + 1'b1;
                        if (host.out_last)
                            chain <= iv_q;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes128_cbc_chain_ctrl.sv
// tb_aes128_cbc_chain_ctrl: directed + randomized CBC bench with a behavioural AES core stand-in
module tb_aes128_cbc_chain_ctrl;
    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;

    logic         clk = 0, reset = 1, iv_load = 0, mode = 0;
    logic [127:0] iv = '0;
    logic         core_start, core_decrypt, core_done, busy;
    logic [127:0] core_din, core_dout;
    logic [15:0]  blk_cnt;

    aes128_cbc_chain_ctrl_if #(.BLK_W(128)) host();

    aes128_cbc_chain_ctrl #(.BLK_W(128), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .iv_load(iv_load), .iv(iv), .mode(mode), .host(host),
        .core_start(core_start), .core_decrypt(core_decrypt), .core_din(core_din),
        .core_done(core_done), .core_dout(core_dout), .busy(busy), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in block cipher: the two NIST CBC steps map exactly, everything else is an invertible toy permutation
    function automatic logic [127:0] enc_f(input logic [127:0] x);
        if (x == (P1 ^ IV0)) return C1;
        if (x == (P2 ^ C1))  return C2;
        return {x[114:0], x[127:115]} ^ KEY;
    endfunction

    function automatic logic [127:0] dec_f(input logic [127:0] y);
        logic [127:0] t;
        if (y == C1) return P1 ^ IV0;
        if (y == C2) return P2 ^ C1;
        t = y ^ KEY;
        return {t[12:0], t[127:13]};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Iterative core model with random latency; flags any change of core_din/core_decrypt while busy
    logic         mdl_done = 0, spur = 0, pend = 0, cap_dec = 0, din_err = 0;
    logic [127:0] mdl_dout = '0, junk = '0, cap_din = '0;
    int           lat = 0, n_start = 0;
    assign core_done = mdl_done | spur;
    assign core_dout = spur ? junk : mdl_dout;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend     <= 0;
            mdl_done <= 0;
            lat      <= 0;
        end else begin
            mdl_done <= 0;
            if (core_start) begin
                n_start <= n_start + 1;
                pend    <= 1;
                cap_din <= core_din;
                cap_dec <= core_decrypt;
                lat     <= int'($urandom_range(1, 6));
            end else if (pend) begin
                if (core_din !== cap_din || core_decrypt !== cap_dec) din_err <= 1;
                if (lat == 1) begin
                    pend     <= 0;
                    mdl_done <= 1;
                    mdl_dout <= cap_dec ? dec_f(cap_din) : enc_f(cap_din);
                end else lat <= lat - 1;
            end
        end
    end

    int npass = 0, ntot = 0;

    task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference CBC state
    logic [127:0] ref_iv = '0, ref_chain = '0, ref_last_out = '0;
    logic         ref_mode = 0;
    logic [15:0]  ref_cnt = '0;

    task automatic load_iv(input logic [127:0] v);
        @(negedge clk); iv_load = 1; iv = v;
        @(negedge clk); iv_load = 0;
        ref_iv = v; ref_chain = v;
    endtask

    // act: 0 none, 1 iv_load while WAIT, 2 stall OUT 20 cycles with a spurious core_done, 3 reset while WAIT
    task automatic xfer(input logic [127:0] d, input bit last, input bit m, input int act, output logic [127:0] got);
        logic [127:0] exp_din, exp_out;
        bit dec, fired;
        int s0;
        dec = (ref_cnt == 0) ? m : ref_mode;
        ref_mode = dec;
        exp_din = dec ? d : d ^ ref_chain;
        exp_out = dec ? dec_f(d) ^ ref_chain : enc_f(exp_din);
        s0 = n_start;
        fired = 0;
        @(negedge clk); host.in_valid = 1; host.in_data = d; host.in_last = last; mode = m;
        @(negedge clk); host.in_valid = 0; mode = ~m;
        for (int i = 0; i < 100 && !host.out_valid; i++) begin
            if (act == 1 && !fired && n_start != s0) begin
                fired = 1; iv_load = 1; iv = rnd128();
                @(negedge clk); iv_load = 0;
            end else if (act == 3 && n_start != s0) begin
                reset = 1; #1;
                chk("reset_in_wait", {host.out_valid, host.out_data, host.out_last, core_start, core_decrypt,
                                      core_din, busy, blk_cnt, host.in_ready}, 278'd1);
                @(negedge clk); reset = 0;
                ref_iv = '0; ref_chain = '0; ref_cnt = '0; ref_last_out = '0;
                got = '0;
                return;
            end else @(negedge clk);
        end
        chk("out_valid_seen", host.out_valid, 1'b1);
        chk("core_din", cap_din, exp_din);
        chk("core_decrypt", cap_dec, dec);
        if (act == 2) begin
            for (int i = 0; i < 20; i++) begin
                if (i == 5) begin spur = 1; junk = rnd128(); end
                if (i == 6) spur = 0;
                @(negedge clk);
            end
            chk("stall_data", host.out_data, exp_out);
            chk("stall_ready_valid", {host.in_ready, host.out_valid}, 2'b01);
            chk("stall_one_start", n_start, s0 + 1);
        end
        got = host.out_data;
        chk("out_data", got, exp_out);
        chk("out_last", host.out_last, last);
        host.out_ready = 1;
        @(negedge clk); host.out_ready = 0;
        ref_cnt = last ? 16'd0 : ref_cnt + 16'd1;
        ref_chain = last ? ref_iv : (dec ? d : exp_out);
        ref_last_out = exp_out;
        chk("post_handshake", {host.out_valid, busy, host.in_ready, blk_cnt}, {3'b001, ref_cnt});
        chk("core_inputs_stable", din_err, 1'b0);
    endtask

    initial begin
        logic [127:0] got, niv;
        int s0, n;
        host.in_valid = 0; host.in_data = '0; host.in_last = 0; host.out_ready = 0;
        repeat (2) @(negedge clk);
        chk("reset_state", {host.out_valid, host.out_data, host.out_last, core_start, core_decrypt,
                            core_din, busy, blk_cnt, host.in_ready}, 278'd1);
        reset = 0;
        // NIST encrypt then decrypt, then a fresh message restarting from the IV
        load_iv(IV0);
        xfer(P1, 0, 0, 0, got); chk("nist_c1", got, C1); chk("cnt_after_c1", blk_cnt, 16'd1);
        xfer(P2, 1, 0, 0, got); chk("nist_c2", got, C2); chk("cnt_after_c2", blk_cnt, 16'd0);
        xfer(C1, 0, 1, 0, got); chk("nist_p1", got, P1);
        xfer(C2, 1, 1, 0, got); chk("nist_p2", got, P2);
        xfer(C1, 1, 1, 0, got); chk("nist_p1_again", got, P1);
        // Output stall with a spurious core_done in OUT
        xfer(rnd128(), 0, 0, 2, got);
        xfer(rnd128(), 1, 0, 0, got);
        // Spurious core_done in IDLE
        @(negedge clk); spur = 1; junk = rnd128();
        @(negedge clk); spur = 0;
        @(negedge clk);
        chk("spur_idle", {busy, host.out_valid, host.out_data, blk_cnt}, {2'b00, ref_last_out, 16'd0});
        // Decrypt message with mode flipped on later blocks
        xfer(rnd128(), 0, 1, 0, got);
        xfer(rnd128(), 0, 0, 0, got);
        xfer(rnd128(), 1, 0, 0, got);
        // Randomized messages
        for (int k = 0; k < 6; k++) begin
            n = int'($urandom_range(1, 4));
            for (int j = 0; j < n; j++) xfer(rnd128(), j == n - 1, 1'($urandom_range(0, 1)), 0, got);
        end
        // iv_load collides with in_valid in IDLE
        niv = rnd128();
        s0 = n_start;
        @(negedge clk); iv_load = 1; iv = niv; host.in_valid = 1; host.in_data = rnd128(); host.in_last = 1;
        #1 chk("collide_in_ready", host.in_ready, 1'b0);
        @(negedge clk); iv_load = 0; host.in_valid = 0;
        @(negedge clk);
        chk("collide_not_accepted", {busy, 32'(n_start)}, {1'b0, 32'(s0)});
        ref_iv = niv; ref_chain = niv;
        xfer(rnd128(), 1, 0, 0, got);
        // iv_load during WAIT is ignored; next message still starts from niv
        xfer(rnd128(), 1, 0, 1, got);
        xfer(rnd128(), 1, 0, 0, got);
        // Reset during WAIT, then reload and repeat the NIST encryption
        xfer(rnd128(), 0, 0, 3, got);
        @(negedge clk);
        load_iv(IV0);
        xfer(P1, 0, 0, 0, got); chk("post_reset_c1", got, C1);
        xfer(P2, 1, 0, 0, got); chk("post_reset_c2", got, C2);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", npass, ntot);
        $fatal(1, "watchdog");
    end
endmodule
